seqdet_rr_sched: RTL and testbench

Round-robin scheduler that time-shares one "101" Moore sequence-detector datapath among NCH serial bit streams. Each channel's detector state is held in a per-channel register file. Each cycle the scheduler grants one requesting channel, steps that channel's state through the shared next-state logic, and writes it back. A registered hit strobe with the channel index, plus a saturating hit counter, are reported to the consumer.

---
 rtl/seqdet_pkg.sv | 21 ++
 rtl/seqdet_rr_sched_rr_arbiter.sv | 34 +++
 rtl/seqdet_rr_sched.sv | 74 +++++++
 tb/tb_seqdet_rr_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared "101" Moore detector definitions: state encoding and pure next-state function.
package seqdet_pkg;

    // A: idle, B: seen "1", C: seen "10", D: seen "101" (hit)
    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } det_state_t;

    function automatic det_state_t next_state(input det_state_t s, input logic b);
        case (s)
            ST_A:    next_state = b ? ST_B : ST_A;
            ST_B:    next_state = b ? ST_B : ST_C;
            ST_C:    next_state = b ? ST_D : ST_A;
            default: next_state = b ? ST_B : ST_C;
        endcase
    endfunction

endpackage

// File: rtl/seqdet_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] grant_idx,
    output logic          grant_any
);

    logic [CW:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single conditional subtract is a full modulo
            pos = {1'b0, ptr} + (CW+1)'(k);
            if (pos >= (CW+1)'(N)) begin
                pos = pos - (CW+1)'(N);
            end
            if (!grant_any && req[pos[CW-1:0]]) begin
                grant_any              = 1'b1;
                grant_idx              = pos[CW-1:0];
                grant[pos[CW-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seqdet_rr_sched.sv
// Time-shares one "101" detector step among NCH serial channels with round-robin grants;
// per-channel state lives in a small register file, hits are strobed and counted.
module seqdet_rr_sched
    import seqdet_pkg::*;
#(
    parameter int NCH = 4,
    parameter int HCW = 16,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req_valid,
    input  logic [NCH-1:0] req_bit,
    output logic [NCH-1:0] req_ready,
    input  logic [NCH-1:0] flush,
    output logic           hit_valid,
    output logic [CW-1:0]  hit_chan,
    output logic [HCW-1:0] hit_count
);

    det_state_t     st [NCH];
    logic [CW-1:0]  ptr;
    logic [NCH-1:0] eligible;
    logic [CW-1:0]  gidx;
    logic           gany;
    det_state_t     nxt;
    logic           hit;

    // Grants are suppressed while reset is held so no bit is consumed into cleared state
    assign eligible = reset ? '0 : (req_valid & ~flush);

    rr_arbiter #(.N(NCH), .CW(CW)) u_arb (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (req_ready),
        .grant_idx (gidx),
        .grant_any (gany)
    );

    always_comb begin
        nxt = next_state(st[gidx], req_bit[gidx]);
        hit = gany && (nxt == ST_D);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                st[i] <= ST_A;
            end
            ptr       <= '0;
            hit_valid <= 1'b0;
            hit_chan  <= '0;
            hit_count <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (flush[i]) begin
                    st[i] <= ST_A;
                end
            end
            if (gany) begin
                st[gidx] <= nxt;
                ptr      <= (gidx == CW'(NCH-1)) ? '0 : gidx + CW'(1);
            end
            hit_valid <= hit;
            if (hit) begin
                hit_chan <= gidx;
                if (hit_count != '1) begin
                    hit_count <= hit_count + HCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Self-checking bench for seqdet_rr_sched (NCH=4, HCW=4): vector table, directed corner
// sequences and randomized traffic against a bit-history reference model.
module tb_seqdet_rr_sched;

    localparam int NCH = 4;
    localparam int HCW = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] req_valid, req_bit, flush, req_ready;
    logic           hit_valid;
    logic [CW-1:0]  hit_chan;
    logic [HCW-1:0] hit_count;

    seqdet_rr_sched #(.NCH(NCH), .HCW(HCW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(req_ready), .flush(flush), .hit_valid(hit_valid),
        .hit_chan(hit_chan), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: last bits seen per channel since reset/flush, pointer, counter
    int       m_ptr;
    logic [2:0] m_hist [NCH];
    int       m_len [NCH];
    int       m_cnt;

    logic [NCH-1:0] got_ready;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_hist[i] = 3'b000;
            m_len[i]  = 0;
        end
    endtask

    function automatic int exp_grant(input logic [NCH-1:0] v, input logic [NCH-1:0] f);
        for (int k = 0; k < NCH; k++) begin
            int j;
            j = (m_ptr + k) % NCH;
            if (v[j] && !f[j]) return j;
        end
        return -1;
    endfunction

    // entered at posedge+1, leaves at posedge+1 after one clock edge
    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic [NCH-1:0] f);
        req_valid = v;
        req_bit   = b;
        flush     = f;
        #2;
        got_ready = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic mstep(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic [NCH-1:0] f);
        int g;
        logic [NCH-1:0] er;
        logic ehit;
        g  = exp_grant(v, f);
        er = (g >= 0) ? (NCH'(1) << g) : '0;
        drive(v, b, f);
        chk("req_ready", 32'(got_ready), 32'(er));
        for (int i = 0; i < NCH; i++) begin
            if (f[i]) begin
                m_hist[i] = 3'b000;
                m_len[i]  = 0;
            end
        end
        ehit = 1'b0;
        if (g >= 0) begin
            m_hist[g] = {m_hist[g][1:0], b[g]};
            if (m_len[g] < 3) m_len[g]++;
            ehit  = (m_len[g] == 3) && (m_hist[g] == 3'b101);
            m_ptr = (g + 1) % NCH;
            if (ehit && m_cnt < (1 << HCW) - 1) m_cnt++;
        end
        chk("hit_valid", 32'(hit_valid), 32'(ehit));
        if (ehit) chk("hit_chan", 32'(hit_chan), 32'(g));
        chk("hit_count", 32'(hit_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        req_valid = '1;
        req_bit   = '0;
        flush     = '0;
        reset     = 1'b1;
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hit_valid", 32'(hit_valid), 32'h0);
        chk("rst_hit_chan", 32'(hit_chan), 32'h0);
        chk("rst_hit_count", 32'(hit_count), 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [NCH-1:0] vld;
        logic [NCH-1:0] bits;
        logic [NCH-1:0] fl;
        logic [NCH-1:0] ready;
        logic           hv;
        logic [CW-1:0]  hc;
        logic [HCW-1:0] cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // all channels valid; ch2 fed 1,0,1 on its grants (rows 2, 6, 10), others 0
        for (int r = 0; r < 12; r++) begin
            tbl[r].vld   = 4'hF;
            tbl[r].fl    = 4'h0;
            tbl[r].bits  = (r == 2 || r == 10) ? 4'b0100 : 4'b0000;
            tbl[r].ready = 4'b0001 << (r % 4);
            tbl[r].hv    = (r == 10);
            tbl[r].hc    = 2'd2;
            tbl[r].cnt   = (r >= 10) ? 4'd1 : 4'd0;
        end

        reset = 1'b1;
        req_valid = '0;
        req_bit = '0;
        flush = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // rotation table
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].vld, tbl[r].bits, tbl[r].fl);
            chk($sformatf("tbl%0d_ready", r), 32'(got_ready), 32'(tbl[r].ready));
            chk($sformatf("tbl%0d_hv", r), 32'(hit_valid), 32'(tbl[r].hv));
            if (tbl[r].hv) chk($sformatf("tbl%0d_hc", r), 32'(hit_chan), 32'(tbl[r].hc));
            chk($sformatf("tbl%0d_cnt", r), 32'(hit_count), 32'(tbl[r].cnt));
        end

        // single channel 0: 1,0,1 -> one pulse after third grant
        do_reset();
        mstep(4'b0001, 4'b0001, 4'b0000);
        mstep(4'b0001, 4'b0000, 4'b0000);
        mstep(4'b0001, 4'b0001, 4'b0000);
        chk("ch0_hit", 32'(hit_valid), 32'h1);
        chk("ch0_cnt", 32'(hit_count), 32'h1);
        mstep(4'b0000, 4'b0000, 4'b0000);
        chk("ch0_pulse_one_cycle", 32'(hit_valid), 32'h0);

        // flush ch1 after 1,0; ch0 still granted in the flush cycle
        do_reset();
        mstep(4'b0010, 4'b0010, 4'b0000);
        mstep(4'b0010, 4'b0000, 4'b0000);
        mstep(4'b0011, 4'b0010, 4'b0010);
        chk("flush_ready", 32'(got_ready), 32'b0001);
        mstep(4'b0010, 4'b0010, 4'b0000);
        chk("flush_no_hit", 32'(hit_valid), 32'h0);
        chk("flush_cnt", 32'(hit_count), 32'h0);

        // ch3 overlap 1,0,1,0,1 -> two hits
        do_reset();
        mstep(4'b1000, 4'b1000, 4'b0000);
        mstep(4'b1000, 4'b0000, 4'b0000);
        mstep(4'b1000, 4'b1000, 4'b0000);
        chk("ovl_hit1", 32'(hit_valid), 32'h1);
        mstep(4'b1000, 4'b0000, 4'b0000);
        mstep(4'b1000, 4'b1000, 4'b0000);
        chk("ovl_hit2", 32'(hit_valid), 32'h1);
        chk("ovl_chan", 32'(hit_chan), 32'h3);
        chk("ovl_cnt", 32'(hit_count), 32'h2);

        // ch0 to state C, then asynchronous reset between edges
        mstep(4'b0001, 4'b0001, 4'b0000);
        mstep(4'b0001, 4'b0000, 4'b0000);
        req_valid = 4'b0001;
        req_bit   = 4'b0001;
        #2;
        reset = 1'b1;
        #1;
        chk("async_cnt", 32'(hit_count), 32'h0);
        chk("async_hv", 32'(hit_valid), 32'h0);
        chk("async_chan", 32'(hit_chan), 32'h0);
        chk("async_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        mstep(4'b0001, 4'b0001, 4'b0000);
        chk("async_restart_no_hit", 32'(hit_valid), 32'h0);

        // saturation: 1 then (0,1)x16 on ch0 -> 16 hits, count stays 15
        do_reset();
        begin
            int pulses;
            pulses = 0;
            mstep(4'b0001, 4'b0001, 4'b0000);
            for (int k = 0; k < 16; k++) begin
                mstep(4'b0001, 4'b0000, 4'b0000);
                mstep(4'b0001, 4'b0001, 4'b0000);
                if (hit_valid) pulses++;
            end
            chk("sat_pulses", 32'(pulses), 32'd16);
            chk("sat_cnt", 32'(hit_count), 32'd15);
        end

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [NCH-1:0] v, b, f;
            v = NCH'($urandom);
            b = NCH'($urandom);
            f = '0;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 7) == 0) f[i] = 1'b1;
            end
            mstep(v, b, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
